// File: rtl/enet_mdio_pkg.sv
// enet_mdio_pkg: shared types and MDIO frame constants for the MDIO master.
// Contents: FSM state enum, start/opcode/turnaround patterns, header width.
package enet_mdio_pkg;
    typedef enum logic [2:0] {S_RESET, S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;
    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;
    localparam int         HDR_BITS   = 14;
endpackage

// File: rtl/enet_mdc_gen.sv
// enet_mdc_gen: free-running MDC divider with one-cycle pre-edge strobes.
// Ports: i_clk/i_rst (sync, active-high); o_mdc management clock (period
// 2*CLKDIV); o_fall_stb / o_rise_stb high in the cycle before each MDC edge.
module enet_mdc_gen #(
    parameter int CLKDIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_mdc,
    output logic o_fall_stb,
    output logic o_rise_stb
);
    localparam int DW = $clog2(CLKDIV);
    logic [DW-1:0] cnt_q;
    logic          mdc_q;
    logic          wrap;
    assign wrap       = cnt_q == DW'(CLKDIV - 1);
    assign o_mdc      = mdc_q;
    assign o_fall_stb = wrap && mdc_q;
    assign o_rise_stb = wrap && !mdc_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            mdc_q <= wrap ? !mdc_q : mdc_q;
        end
    end
endmodule

// File: rtl/enet_mdio.sv
// enet_mdio: wishbone-pipelined MDIO (clause 22) master, one request at a time.
// Ports: i_clk/i_rst (sync, active-high); i_wb_cyc/stb/we, i_wb_addr {PHY,REG},
// i_wb_data write data; o_wb_ack, o_wb_stall, o_wb_data {15'h0, err, rdata};
// o_mdc management clock, o_mdio/o_mdwe pin drive and enable, i_mdio pin value.
module enet_mdio
    import enet_mdio_pkg::*;
#(
    parameter int CLKDIV        = 4,
    parameter int PREAMBLE_BITS = 32,
    parameter int RESET_BITS    = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [9:0]  i_wb_addr,
    input  logic [15:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_mdc,
    output logic        o_mdio,
    output logic        o_mdwe,
    input  logic        i_mdio
);
    localparam int CW = $clog2(RESET_BITS > 32 ? RESET_BITS : 32);
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_m1;
    logic [HDR_BITS-1:0]   hdr_q, hdr_d;
    logic [15:0]           data_q, data_d, rdata_q, rdata_d;
    logic                  req_q, req_d, we_q, we_d, cyc_ok_q, cyc_ok_d;
    logic                  err_sh_q, err_sh_d, err_q, err_d, mdio_q, mdio_d, mdwe_q, mdwe_d;
    logic                  fall_stb, rise_stb, last, accept;
    enet_mdc_gen #(.CLKDIV(CLKDIV)) u_mdc (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .o_mdc      (o_mdc),
        .o_fall_stb (fall_stb),
        .o_rise_stb (rise_stb)
    );
    // cnt_q counts down the bits left in the current field; each field's first
    // bit is loaded by the fall_stb that leaves the previous field.
    assign cnt_m1     = cnt_q - 1'b1;
    assign last       = cnt_q == '0;
    assign o_wb_stall = (state_q != S_IDLE) || req_q;
    assign accept     = i_wb_stb && !o_wb_stall;
    assign o_wb_ack   = (state_q == S_DONE) && cyc_ok_q;
    assign o_wb_data  = {15'h0, err_q, rdata_q};
    assign o_mdio     = mdio_q;
    assign o_mdwe     = mdwe_q;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hdr_d    = hdr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        req_d    = req_q;
        we_d     = we_q;
        cyc_ok_d = cyc_ok_q && i_wb_cyc;
        err_sh_d = err_sh_q;
        err_d    = err_q;
        mdio_d   = mdio_q;
        mdwe_d   = mdwe_q;
        case (state_q)
            S_RESET: if (fall_stb) begin
                cnt_d   = cnt_m1;
                state_d = last ? S_IDLE : S_RESET;
                mdwe_d  = !last;
            end
            S_IDLE: if (accept) begin
                req_d    = 1'b1;
                we_d     = i_wb_we;
                cyc_ok_d = i_wb_cyc;
                hdr_d    = {MDIO_ST, i_wb_we ? MDIO_OP_WR : MDIO_OP_RD, i_wb_addr};
                data_d   = i_wb_data;
            end else if (req_q && fall_stb) begin
                req_d  = 1'b0;
                mdwe_d = 1'b1;
                if (PREAMBLE_BITS > 0) begin
                    state_d = S_PRE;
                    cnt_d   = CW'(PREAMBLE_BITS - 1);
                    mdio_d  = 1'b1;
                end else begin
                    state_d = S_HDR;
                    cnt_d   = CW'(HDR_BITS - 1);
                    mdio_d  = hdr_q[HDR_BITS-1];
                end
            end
            S_PRE: if (fall_stb) begin
                state_d = last ? S_HDR : S_PRE;
                cnt_d   = last ? CW'(HDR_BITS - 1) : cnt_m1;
                mdio_d  = last ? hdr_q[HDR_BITS-1] : 1'b1;
            end
            S_HDR: if (fall_stb) begin
                // reads release the pin for the whole turnaround
                state_d = last ? S_TA : S_HDR;
                cnt_d   = last ? CW'(1) : cnt_m1;
                mdwe_d  = last ? we_q : 1'b1;
                mdio_d  = last ? (!we_q || MDIO_TA_WR[1]) : hdr_q[cnt_m1[3:0]];
            end
            S_TA: begin
                // a PHY pulls the second turnaround bit low; a pulled-up 1 means no PHY
                err_sh_d = (rise_stb && last) ? i_mdio : err_sh_q;
                if (fall_stb) begin
                    state_d = last ? S_DATA : S_TA;
                    cnt_d   = last ? CW'(15) : cnt_m1;
                    mdio_d  = !we_q || (last ? data_q[15] : MDIO_TA_WR[0]);
                end
            end
            S_DATA: begin
                data_d = (rise_stb && !we_q) ? {data_q[14:0], i_mdio} : data_q;
                if (fall_stb) begin
                    cnt_d  = cnt_m1;
                    mdio_d = last || !we_q || data_q[cnt_m1[3:0]];
                    if (last) begin
                        state_d = S_DONE;
                        mdwe_d  = 1'b0;
                        err_d   = !we_q && err_sh_q;
                        rdata_d = we_q ? rdata_q : data_q;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_RESET;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_RESET;
            cnt_q    <= CW'(RESET_BITS - 1);
            hdr_q    <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            cyc_ok_q <= 1'b0;
            err_sh_q <= 1'b0;
            err_q    <= 1'b0;
            mdio_q   <= 1'b1;
            mdwe_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hdr_q    <= hdr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            cyc_ok_q <= cyc_ok_d;
            err_sh_q <= err_sh_d;
            err_q    <= err_d;
            mdio_q   <= mdio_d;
            mdwe_q   <= mdwe_d;
        end
    end
endmodule

// File: tb/tb_enet_mdio.sv
// tb_enet_mdio: self-checking bench for enet_mdio (32-bit and suppressed preamble).
module tb_enet_mdio;
    localparam int CLKDIV = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc [2];
    logic        stb [2];
    logic        we [2];
    logic [9:0]  addr [2];
    logic [15:0] wdat [2];
    logic        ack [2];
    logic        stall [2];
    logic [31:0] rdat [2];
    logic        mdc [2];
    logic        mdo [2];
    logic        mdwe [2];
    logic        cap_on [2];
    logic        phy_arm [2];
    logic [16:0] phy_resp [2];
    logic [31:0] exp_rd [2];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Channel 0: full preamble, 64 reset periods. Channel 1: no preamble, 8 reset periods.
    for (genvar g = 0; g < 2; g++) begin : ch
        localparam int P = (g == 0) ? 32 : 0;
        localparam int R = (g == 0) ? 64 : 8;
        logic       mdi = 1'b1;
        logic [1:0] cap [64];
        int         ncap = 0;
        bit         started = 1'b0;
        enet_mdio #(.CLKDIV(CLKDIV), .PREAMBLE_BITS(P), .RESET_BITS(R)) u_dut (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_wb_cyc  (cyc[g]),
            .i_wb_stb  (stb[g]),
            .i_wb_we   (we[g]),
            .i_wb_addr (addr[g]),
            .i_wb_data (wdat[g]),
            .o_wb_ack  (ack[g]),
            .o_wb_stall(stall[g]),
            .o_wb_data (rdat[g]),
            .o_mdc     (mdc[g]),
            .o_mdio    (mdo[g]),
            .o_mdwe    (mdwe[g]),
            .i_mdio    (mdi)
        );
        // Record the line at every MDC rising edge, starting at the first driven bit.
        always @(posedge mdc[g]) begin
            if (!cap_on[g]) begin
                ncap = 0;
                started = 1'b0;
            end else begin
                if (mdwe[g]) started = 1'b1;
                if (started && ncap < 64) begin
                    cap[ncap[5:0]] = {mdwe[g], mdo[g]};
                    ncap++;
                end
            end
        end
        // PHY model: answers second TA bit and 16 data bits after MDC falls; pull-up otherwise.
        always @(negedge mdc[g]) begin
            logic [16:0] t;
            #1;
            t = phy_resp[g] >> (P + 31 - ncap);
            mdi = (phy_arm[g] && ncap >= P + 15 && ncap <= P + 31) ? t[0] : 1'b1;
        end
    end

    function automatic int pre_of(int d);
        return d == 0 ? 32 : 0;
    endfunction
    function automatic int ncap_of(int d);
        return d == 0 ? ch[0].ncap : ch[1].ncap;
    endfunction
    function automatic logic [1:0] cap_of(int d, int k);
        logic [5:0] i;
        i = k[5:0];
        return d == 0 ? ch[0].cap[i] : ch[1].cap[i];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_all();
        int  cnt [2];
        bit  up [2];
        int  bad;
        int  acks;
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0;
            stb[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_stall", 32'(stall[d]), 1);
            chk("rst_ack", 32'(ack[d]), 0);
            chk("rst_mdio", 32'(mdo[d]), 1);
            chk("rst_mdwe", 32'(mdwe[d]), 1);
            chk("rst_mdc", 32'(mdc[d]), 0);
            chk("rst_rdata", rdat[d], 0);
            exp_rd[d] = '0;
            cnt[d] = 0;
            up[d] = 1'b1;
        end
        rst = 1'b0;
        bad = 0;
        acks = 0;
        for (int c = 0; c < 700 && (up[0] || up[1]); c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                if (up[d]) begin
                    if (stall[d]) begin
                        cnt[d]++;
                        if (!mdo[d] || !mdwe[d]) bad++;
                    end else up[d] = 1'b0;
                end
            acks += int'(ack[0]) + int'(ack[1]);
        end
        // Cycle of release plus cnt equals RESET_BITS MDC periods.
        chk("rst_len0", 32'(cnt[0] >= 511 && cnt[0] <= 511 + 2 * CLKDIV), 1);
        chk("rst_len1", 32'(cnt[1] >= 63 && cnt[1] <= 63 + 2 * CLKDIV), 1);
        chk("rst_line_ones", bad, 0);
        chk("rst_no_ack", acks, 0);
        chk("rst_exit0", 32'(stall[0]), 0);
        chk("rst_exit1", 32'(stall[1]), 0);
        chk("idle_mdwe", 32'(mdwe[0]), 0);
    endtask

    task automatic issue(int d, bit w, logic [9:0] a, logic [15:0] wd, bit phy_ok, logic [15:0] pd);
        cap_on[d] = 1'b0;
        phy_arm[d] = 1'b0;
        repeat (2 * CLKDIV + 2) @(negedge clk);
        chk("idle_before_req", 32'(stall[d]), 0);
        cap_on[d] = 1'b1;
        phy_arm[d] = !w && phy_ok;
        phy_resp[d] = {1'b0, pd};
        cyc[d] = 1'b1;
        stb[d] = 1'b1;
        we[d] = w;
        addr[d] = a;
        wdat[d] = wd;
        @(negedge clk);
        stb[d] = 1'b0;
        chk("stall_after_accept", 32'(stall[d]), 1);
    endtask

    task automatic finish(int d, bit w, logic [9:0] a, logic [15:0] wd, bit phy_ok,
                          logic [15:0] pd, bit drop, bit poke);
        int          p;
        int          n;
        int          acks;
        int          bad;
        logic [31:0] got;
        logic [13:0] hdr;
        logic [13:0] th;
        logic [15:0] td;
        logic [1:0]  e;
        logic [1:0]  m;
        p = pre_of(d);
        acks = 0;
        bad = 0;
        got = 'x;
        if (poke) begin
            stb[d] = 1'b1;
            we[d] = !w;
            addr[d] = ~a;
            wdat[d] = ~wd;
            @(negedge clk);
            stb[d] = 1'b0;
        end
        if (drop) begin
            n = 0;
            while (ncap_of(d) < 8 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            cyc[d] = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (ack[d]) begin
                acks++;
                got = rdat[d];
            end
        end while (stall[d] && n < (p + 40) * 2 * CLKDIV);
        chk("done_timeout", 32'(stall[d]), 0);
        cap_on[d] = 1'b0;
        cyc[d] = 1'b1;
        if (!drop)
            exp_rd[d] = w ? (exp_rd[d] & 32'h0000_FFFF)
                          : {15'h0, !phy_ok, phy_ok ? pd : 16'hFFFF};
        chk("ack_count", acks, drop ? 0 : 1);
        if (!drop) chk("ack_data", got, exp_rd[d]);
        chk("hold_data", rdat[d], exp_rd[d]);
        chk("frame_len", ncap_of(d), p + 32);
        hdr = {2'b01, w ? 2'b01 : 2'b10, a};
        for (int k = 0; k < p + 32; k++) begin
            m = 2'b11;
            if (k < p) e = 2'b11;
            else if (k < p + 14) begin
                th = hdr >> (13 - (k - p));
                e = {1'b1, th[0]};
            end else if (k < p + 16) begin
                e = w ? {1'b1, k == p + 14} : 2'b00;
                m = w ? 2'b11 : 2'b10;
            end else begin
                td = wd >> (p + 31 - k);
                e = w ? {1'b1, td[0]} : 2'b00;
                m = w ? 2'b11 : 2'b10;
            end
            if ((cap_of(d, k) & m) !== (e & m)) bad++;
        end
        chk("wire_bits", bad, 0);
    endtask

    task automatic xact(int d, bit w, logic [9:0] a, logic [15:0] wd, bit phy_ok,
                        logic [15:0] pd, bit drop, bit poke);
        issue(d, w, a, wd, phy_ok, pd);
        finish(d, w, a, wd, phy_ok, pd, drop, poke);
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0;
            stb[d] = 1'b0;
            we[d] = 1'b0;
            addr[d] = '0;
            wdat[d] = '0;
            cap_on[d] = 1'b0;
            phy_arm[d] = 1'b0;
            phy_resp[d] = '0;
            exp_rd[d] = '0;
        end
        reset_all();
        xact(0, 1'b1, {5'h01, 5'h00}, 16'h1140, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("write_err_clear", rdat[0], 32'h0000_0000);
        xact(0, 1'b0, {5'h03, 5'h02}, 16'h0, 1'b1, 16'h2000, 1'b0, 1'b0);
        chk("read_phy", rdat[0], 32'h0000_2000);
        xact(0, 1'b0, {5'h1E, 5'h11}, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("read_no_phy", rdat[0], 32'h0001_FFFF);
        xact(0, 1'b1, {5'h04, 5'h05}, 16'h0F0F, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("write_keeps_rdata", rdat[0], 32'h0000_FFFF);
        xact(1, 1'b0, {5'h09, 5'h1C}, 16'h0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        xact(1, 1'b1, {5'h1F, 5'h1F}, 16'h55AA, 1'b0, 16'h0, 1'b1, 1'b0);
        xact(1, 1'b0, {5'h00, 5'h01}, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            xact($urandom_range(0, 1), 1'($urandom), 10'($urandom), 16'($urandom),
                 $urandom_range(0, 3) != 0, 16'($urandom), 1'b0, 1'($urandom));
        issue(0, 1'b0, {5'h07, 5'h0A}, 16'h0, 1'b1, 16'h1234);
        n = 0;
        while (ncap_of(0) < 32 + 6 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("hdr5_reached", 32'(ncap_of(0) >= 38), 1);
        reset_all();
        xact(0, 1'b1, {5'h02, 5'h03}, 16'hA5C3, 1'b0, 16'h0, 1'b0, 1'b0);
        xact(0, 1'b0, {5'h02, 5'h03}, 16'h0, 1'b1, 16'h8001, 1'b0, 1'b0);
        chk("after_reset_read", rdat[0], 32'h0000_8001);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/enet_mdio.md
ENET_MDIO -- requirements
Module: enet_mdio

Interface
REQ-001 SHALL have parameters: CLKDIV, 4, i_clk cycles per MDC half-period (>=2); PREAMBLE_BITS, 32, preamble ones per frame (0..32, 0 = suppressed); RESET_BITS, 64, MDC periods of ones after reset.
REQ-002 SHALL have ports: i_clk input 1, clock; i_rst input 1, synchronous active-high reset.
REQ-003 SHALL have ports: i_wb_cyc, i_wb_stb, i_wb_we input 1 each, pipelined wishbone request.
REQ-004 SHALL have port i_wb_addr input 10, {PHY[9:5], REG[4:0]}, so any of 32 PHYs is addressable.
REQ-005 SHALL have ports: i_wb_data input 16, write data; o_wb_ack output 1; o_wb_stall output 1.
REQ-006 SHALL have port o_wb_data output 32, {15'h0, err, rdata[15:0]}.
REQ-007 SHALL have ports: o_mdc output 1, management clock; o_mdio output 1, data out; o_mdwe output 1, 1 = drive pin; i_mdio input 1, pin value.

Function
REQ-008 SHALL generate o_mdc free-running with period 2*CLKDIV i_clk cycles, plus one-cycle strobes fall_stb and rise_stb in the cycle before each MDC edge.
REQ-009 SHALL change o_mdio/o_mdwe only on fall_stb and sample i_mdio only on rise_stb.
REQ-010 SHALL use states RESET, IDLE, PRE, HDR, TA, DATA, DONE.
REQ-011 RESET: o_mdwe=1, o_mdio=1 for RESET_BITS MDC periods, stall=1, then IDLE.
REQ-012 IDLE: stall=0; request accepted when i_wb_stb && !o_wb_stall; PHY, REG, we, data latched; stall=1 the next cycle.
REQ-013 On accept, SHALL enter PRE (or HDR if PREAMBLE_BITS=0) at the next fall_stb.
REQ-014 PRE drives PREAMBLE_BITS ones; HDR drives 14 bits MSB-first: ST 01, OP (01 write / 10 read), PHY[4:0], REG[4:0].
REQ-015 TA write: o_mdwe=1, drives 1,0; TA read: o_mdwe=0 for both bits; second TA bit sampled; if 1, err=1 (no PHY).
REQ-016 DATA: 16 bits MSB-first; write drives latched data, o_mdwe=1; read keeps o_mdwe=0 and shifts i_mdio into rdata on each rise_stb.
REQ-017 DONE: at the fall_stb ending data bit 0, o_mdwe=0, o_mdio=1; o_wb_ack=1 for one cycle in the same cycle; state IDLE; stall drops next cycle.
REQ-018 Transaction length SHALL be PREAMBLE_BITS+32 MDC periods from first fall_stb; only one outstanding request.
REQ-019 o_wb_data SHALL hold rdata/err from last read until next read completes; writes clear err and leave rdata unchanged.
REQ-020 If i_wb_cyc drops mid-frame, frame SHALL complete on the wire, ack suppressed, return to IDLE.
REQ-021 stb while stall=1 SHALL be ignored (no latch, no ack).
REQ-022 Line SHALL idle with o_mdwe=0 in IDLE.

Reset
REQ-023 i_rst SHALL, at any time incl. mid-frame, force state RESET, o_wb_ack=0, o_wb_stall=1, o_mdio=1, o_mdwe=1, rdata=0, err=0, divider restarted with o_mdc=0.
REQ-024 Frame in progress at reset SHALL be abandoned without ack.

Structure
REQ-025 Shared package enet_mdio_pkg SHALL hold state enum, ST/OP/TA constants, header width 14.
REQ-026 Sub-module enet_mdc_gen (parameter CLKDIV) SHALL produce o_mdc, fall_stb, rise_stb.

Verification
REQ-027 Reset, RESET_BITS=64, CLKDIV=4 -> stall high 512+ cycles, o_mdio=1 throughout, then stall=0.
REQ-028 Write addr {5'h01,5'h00} data 16'h1140 -> wire bits 32x1, 0101 00001 00000 10 0001000101000000, one ack, err=0.
REQ-029 Read addr {5'h03,5'h02}, PHY model returns TA bit 0 then 16'h2000 -> o_wb_data=32'h0000_2000 with ack.
REQ-030 Read with no PHY (pull-up, i_mdio=1) -> o_wb_data=32'h0001_FFFF.
REQ-031 PREAMBLE_BITS=0 -> frame 32 MDC periods; cyc dropped mid-frame -> frame completes, no ack.
REQ-032 i_rst asserted at HDR bit 5 -> no ack, 64 reset periods, next request served normally.
